// File: rtl/flag_pkg.sv
// rtl/flag_pkg.sv - shared definitions for the NZCV flag write controller
//
// Purpose : condition-field encodings, NZCV bit indices, FSM state encoding
//           and the masked-merge helper used for direct flag writes.
// Ports   : none (package).
package flag_pkg;

  // ARM condition field encodings
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  // NZCV bit positions within the 4-bit flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // MSR handshake FSM
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_e;

  // Replace only the bits selected by mask, keep the rest of the old flags
  function automatic logic [3:0] msr_merge(input logic [3:0] old_flags,
                                           input logic [3:0] new_flags,
                                           input logic [3:0] mask);
    return (old_flags & ~mask) | (new_flags & mask);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational ARM condition-code evaluator
//
// Purpose : decide whether a condition field passes for a given NZCV value.
// Ports   : COND [3:0] in  - condition field (EQ=0000 .. AL=1110, NV=1111)
//           F    [3:0] in  - NZCV flags (N=3, Z=2, C=1, V=0)
//           pass       out - condition result
module cond_eval
  import flag_pkg::*;
(
  input  logic [3:0] COND,
  input  logic [3:0] F,
  output logic       pass
);

  logic n, z, c, v;

  assign n = F[FLAG_N];
  assign z = F[FLAG_Z];
  assign c = F[FLAG_C];
  assign v = F[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (COND)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;  // NV never passes
    endcase
  end

endmodule

// File: rtl/flag_write_ctrl.sv
// rtl/flag_write_ctrl.sv - arbitrated NZCV flag register with MSR handshake
//
// Purpose : holds the architectural NZCV flags, arbitrates between ALU flag
//           writes and masked MSR writes (ALU first, MSR forced after
//           MSR_WAIT_MAX consecutive losses) and registers condition results.
// Config  : FLAG_BYPASS_EN - when defined, condition evaluation sees the
//           flags being written in the same cycle; otherwise the current ones.
// Ports   : CLK, RST_N (async, active-low)
//           ALU_VALID, ALU_S, ALU_FLAGS[3:0]  - ALU flag write request
//           MSR_REQ, MSR_FLAGS[3:0], MSR_MASK[3:0], MSR_ACK - MSR handshake
//           COND_VALID, COND[3:0] -> COND_PASS, COND_PASS_VALID
//           FLAGS[3:0], FLAG_WE - flag state and delayed write pulse
//           STALL - ALU write refused this cycle
module flag_write_ctrl
  import flag_pkg::*;
#(
  parameter int MSR_WAIT_MAX = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       ALU_VALID,
  input  logic       ALU_S,
  input  logic [3:0] ALU_FLAGS,
  input  logic       MSR_REQ,
  input  logic [3:0] MSR_FLAGS,
  input  logic [3:0] MSR_MASK,
  input  logic       COND_VALID,
  input  logic [3:0] COND,
  output logic [3:0] FLAGS,
  output logic       FLAG_WE,
  output logic       MSR_ACK,
  output logic       STALL,
  output logic       COND_PASS,
  output logic       COND_PASS_VALID
);

  localparam logic [3:0] WAIT_MAX = 4'(MSR_WAIT_MAX);

  state_e     state;
  logic [3:0] wait_cnt;
  logic       wr_pend;   // a flag write happened at the last edge
  logic       alu_wr;
  logic       msr_wr;
  logic       msr_win;
  logic       alu_grant;
  logic [3:0] flags_next;
  logic [3:0] cond_flags;
  logic       pass;

  assign alu_wr    = ALU_VALID & ALU_S;
  assign msr_wr    = MSR_REQ & (state == ST_IDLE);
  // MSR only beats a live ALU write once it has waited its full budget
  assign msr_win   = msr_wr & (~alu_wr | (wait_cnt == WAIT_MAX));
  assign alu_grant = alu_wr & ~msr_win;
  assign STALL     = RST_N & alu_wr & msr_win;

  always_comb begin
    flags_next = FLAGS;
    if (alu_grant) begin
      flags_next = ALU_FLAGS;
    end else if (msr_win) begin
      flags_next = msr_merge(FLAGS, MSR_FLAGS, MSR_MASK);
    end
  end

`ifdef FLAG_BYPASS_EN
  assign cond_flags = flags_next;
`else
  assign cond_flags = FLAGS;
`endif

  cond_eval u_cond_eval (
    .COND (COND),
    .F    (cond_flags),
    .pass (pass)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state           <= ST_IDLE;
      wait_cnt        <= 4'd0;
      wr_pend         <= 1'b0;
      FLAGS           <= 4'b0000;
      FLAG_WE         <= 1'b0;
      MSR_ACK         <= 1'b0;
      COND_PASS       <= 1'b0;
      COND_PASS_VALID <= 1'b0;
    end else begin
      FLAGS           <= flags_next;
      // an MSR grant counts as a write even when the mask leaves FLAGS intact
      wr_pend         <= msr_win | (flags_next != FLAGS);
      FLAG_WE         <= wr_pend;
      COND_PASS_VALID <= COND_VALID;
      COND_PASS       <= pass;

      if (!MSR_REQ || msr_win) begin
        wait_cnt <= 4'd0;
      end else if (msr_wr && alu_grant && (wait_cnt != WAIT_MAX)) begin
        wait_cnt <= wait_cnt + 4'd1;
      end

      case (state)
        ST_IDLE: begin
          if (msr_win) begin
            state   <= ST_ACK;
            MSR_ACK <= 1'b1;
          end else begin
            MSR_ACK <= 1'b0;
          end
        end
        ST_ACK: begin
          state   <= ST_IDLE;
          MSR_ACK <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          MSR_ACK <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flag_write_ctrl.sv
// tb/tb_flag_write_ctrl.sv - scoreboard bench for flag_write_ctrl
module tb_flag_write_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       ALU_VALID, ALU_S;
  logic [3:0] ALU_FLAGS;
  logic       MSR_REQ;
  logic [3:0] MSR_FLAGS, MSR_MASK;
  logic       COND_VALID;
  logic [3:0] COND;
  logic [3:0] FLAGS;
  logic       FLAG_WE, MSR_ACK, STALL, COND_PASS, COND_PASS_VALID;

  int checks = 0;
  int errors = 0;

  logic [3:0] q_we[$];    // FLAGS value expected to be reported by each FLAG_WE pulse
  logic [3:0] q_msr[$];   // FLAGS value expected in each MSR_ACK cycle
  logic       q_cond[$];  // expected COND_PASS per COND_PASS_VALID
  logic [3:0] flags_prev = 4'b0000;

  flag_write_ctrl #(.MSR_WAIT_MAX(4)) dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .ALU_VALID       (ALU_VALID),
    .ALU_S           (ALU_S),
    .ALU_FLAGS       (ALU_FLAGS),
    .MSR_REQ         (MSR_REQ),
    .MSR_FLAGS       (MSR_FLAGS),
    .MSR_MASK        (MSR_MASK),
    .COND_VALID      (COND_VALID),
    .COND            (COND),
    .FLAGS           (FLAGS),
    .FLAG_WE         (FLAG_WE),
    .MSR_ACK         (MSR_ACK),
    .STALL           (STALL),
    .COND_PASS       (COND_PASS),
    .COND_PASS_VALID (COND_PASS_VALID)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // monitor: pops expectations whenever the DUT presents a qualified output
  always @(negedge CLK) begin
    if (FLAG_WE) begin
      if (q_we.size() == 0) chk("unexpected_flag_we", 4'(FLAG_WE), 4'b0000);
      else chk("flag_we_value", flags_prev, q_we.pop_front());
    end
    if (MSR_ACK) begin
      if (q_msr.size() == 0) chk("unexpected_msr_ack", 4'(MSR_ACK), 4'b0000);
      else chk("msr_ack_flags", FLAGS, q_msr.pop_front());
    end
    if (COND_PASS_VALID) begin
      if (q_cond.size() == 0) chk("unexpected_cond_valid", 4'(COND_PASS_VALID), 4'b0000);
      else chk("cond_pass", 4'(COND_PASS), 4'(q_cond.pop_front()));
    end
    flags_prev = FLAGS;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; ALU_VALID = 1'b0; ALU_S = 1'b0; ALU_FLAGS = 4'b0000;
    MSR_REQ = 1'b0; MSR_FLAGS = 4'b0000; MSR_MASK = 4'b0000;
    COND_VALID = 1'b0; COND = 4'b0000;
    tick(); tick();
    chk("rst_flags", FLAGS, 4'b0000);
    chk("rst_flag_we", 4'(FLAG_WE), 4'b0000);
    chk("rst_msr_ack", 4'(MSR_ACK), 4'b0000);
    chk("rst_stall", 4'(STALL), 4'b0000);
    chk("rst_cond_pass_valid", 4'(COND_PASS_VALID), 4'b0000);
    RST_N = 1'b1;
    tick();

    // ALU flag write, then S=0 must not write
    ALU_VALID = 1'b1; ALU_S = 1'b1; ALU_FLAGS = 4'b0100; q_we.push_back(4'b0100);
    tick();
    chk("alu_write", FLAGS, 4'b0100);
    ALU_S = 1'b0; ALU_FLAGS = 4'b1111;
    tick();
    chk("alu_s0_hold", FLAGS, 4'b0100);
    ALU_VALID = 1'b0;

    // conditions against FLAGS=0100 (Z set)
    begin
      logic [3:0] cv[4]  = '{4'b0000, 4'b0001, 4'b1111, 4'b1110};
      logic       ce[4]  = '{1'b1,    1'b0,    1'b0,    1'b1};
      COND_VALID = 1'b1;
      for (int i = 0; i < 4; i++) begin
        COND = cv[i]; q_cond.push_back(ce[i]);
        tick();
      end
      COND_VALID = 1'b0;
    end

    // FLAGS=1001 (N,V set): GT=1, LT=0, LE=0, GE=1
    ALU_VALID = 1'b1; ALU_S = 1'b1; ALU_FLAGS = 4'b1001; q_we.push_back(4'b1001);
    tick();
    ALU_VALID = 1'b0;
    begin
      logic [3:0] cv[4] = '{4'b1100, 4'b1011, 4'b1101, 4'b1010};
      logic       ce[4] = '{1'b1,    1'b0,    1'b0,    1'b1};
      COND_VALID = 1'b1;
      for (int i = 0; i < 4; i++) begin
        COND = cv[i]; q_cond.push_back(ce[i]);
        tick();
      end
      COND_VALID = 1'b0;
    end

    // masked MSR write: 1111 with flags 0000 mask 1010 -> 0101
    ALU_VALID = 1'b1; ALU_FLAGS = 4'b1111; q_we.push_back(4'b1111);
    tick();
    ALU_VALID = 1'b0;
    MSR_REQ = 1'b1; MSR_FLAGS = 4'b0000; MSR_MASK = 4'b1010;
    q_msr.push_back(4'b0101); q_we.push_back(4'b0101);
    tick();
    chk("msr_ack_high", 4'(MSR_ACK), 4'b0001);
    chk("msr_masked", FLAGS, 4'b0101);
    MSR_REQ = 1'b0;
    tick();
    chk("msr_ack_one_cycle", 4'(MSR_ACK), 4'b0000);

    // zero mask: FLAGS unchanged but FLAG_WE still pulses
    MSR_REQ = 1'b1; MSR_FLAGS = 4'b1111; MSR_MASK = 4'b0000;
    q_msr.push_back(4'b0101); q_we.push_back(4'b0101);
    tick();
    MSR_REQ = 1'b0;
    tick();
    chk("msr_mask0_flags", FLAGS, 4'b0101);

    // starvation: 4 ALU wins, MSR forced with STALL, ALU succeeds in ACK
    MSR_REQ = 1'b1; MSR_FLAGS = 4'b1111; MSR_MASK = 4'b1111;
    ALU_VALID = 1'b1; ALU_S = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ALU_FLAGS = 4'(i + 1); q_we.push_back(4'(i + 1));
      @(negedge CLK);
      chk("alu_win_no_stall", 4'(STALL), 4'b0000);
      tick();
      chk("alu_win_flags", FLAGS, 4'(i + 1));
    end
    ALU_FLAGS = 4'b1000;
    q_msr.push_back(4'b1111); q_we.push_back(4'b1111);
    @(negedge CLK);
    chk("msr_forced_stall", 4'(STALL), 4'b0001);
    tick();
    chk("msr_forced_flags", FLAGS, 4'b1111);
    MSR_REQ = 1'b0; q_we.push_back(4'b1000);
    @(negedge CLK);
    chk("ack_cycle_no_stall", 4'(STALL), 4'b0000);
    tick();
    chk("alu_in_ack", FLAGS, 4'b1000);
    ALU_VALID = 1'b0;

    // same-cycle write 0000 over 0100 with COND=EQ
    ALU_VALID = 1'b1; ALU_FLAGS = 4'b0100; q_we.push_back(4'b0100);
    tick();
    ALU_FLAGS = 4'b0000; q_we.push_back(4'b0000);
    COND_VALID = 1'b1; COND = 4'b0000;
`ifdef FLAG_BYPASS_EN
    q_cond.push_back(1'b0);
`else
    q_cond.push_back(1'b1);
`endif
    tick();
    ALU_VALID = 1'b0; COND_VALID = 1'b0;
    tick(); tick();

    // reset during ACK: everything clears at once, no later ACK
    MSR_REQ = 1'b1; MSR_FLAGS = 4'b0011; MSR_MASK = 4'b1111;
    COND_VALID = 1'b1; COND = 4'b1110;
    @(posedge CLK);
    #1;
    chk("pre_rst_ack", 4'(MSR_ACK), 4'b0001);
    chk("pre_rst_cond", 4'(COND_PASS), 4'b0001);
    RST_N = 1'b0;
    #1;
    chk("async_rst_flags", FLAGS, 4'b0000);
    chk("async_rst_ack", 4'(MSR_ACK), 4'b0000);
    chk("async_rst_cond_pass", 4'(COND_PASS), 4'b0000);
    chk("async_rst_cond_valid", 4'(COND_PASS_VALID), 4'b0000);
    chk("async_rst_stall", 4'(STALL), 4'b0000);
    MSR_REQ = 1'b0; COND_VALID = 1'b0;
    tick(); tick();
    chk("rst_held_flag_we", 4'(FLAG_WE), 4'b0000);
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_no_ack", 4'(MSR_ACK), 4'b0000);
      chk("post_rst_flags", FLAGS, 4'b0000);
    end

    tick(); tick();
    chk("we_queue_drained", 4'(q_we.size()), 4'd0);
    chk("msr_queue_drained", 4'(q_msr.size()), 4'd0);
    chk("cond_queue_drained", 4'(q_cond.size()), 4'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flag_write_ctrl.md
FLAG_WRITE_CTRL -- requirements
Module: flag_write_ctrl

Interface
REQ-001 SHALL have parameter MSR_WAIT_MAX, default 4: number of consecutive cycles an MSR request may lose arbitration to the ALU before it is forced to win (range 1..15).
REQ-002 SHALL have port CLK, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST_N, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port ALU_VALID, input, 1: ALU result valid this cycle.
REQ-005 SHALL have port ALU_S, input, 1: the instruction's S bit; with ALU_VALID, requests a flag write.
REQ-006 SHALL have port ALU_FLAGS, input, 4: new NZCV from the ALU; bit 3=N, 2=Z, 1=C, 0=V.
REQ-007 SHALL have port MSR_REQ, input, 1: request a masked direct flag write; held high until MSR_ACK.
REQ-008 SHALL have port MSR_FLAGS, input, 4: NZCV value for the MSR write.
REQ-009 SHALL have port MSR_MASK, input, 4: per-bit write mask for the MSR write.
REQ-010 SHALL have port COND_VALID, input, 1: condition evaluation request.
REQ-011 SHALL have port COND, input, 4: ARM condition field, EQ=0000 .. AL=1110, NV=1111.
REQ-012 SHALL have port FLAGS, output, 4: architectural NZCV.
REQ-013 SHALL have port FLAG_WE, output, 1: one-cycle pulse, registered, the cycle after any FLAGS change.
REQ-014 SHALL have port MSR_ACK, output, 1: one-cycle pulse completing an MSR write.
REQ-015 SHALL have port STALL, output, 1: ALU flag write refused this cycle; the pipeline holds its ALU inputs.
REQ-016 SHALL have port COND_PASS, output, 1: registered condition result.
REQ-017 SHALL have port COND_PASS_VALID, output, 1: COND_PASS qualifier.

Function
REQ-018 SHALL, each cycle, form alu_wr = ALU_VALID & ALU_S and msr_wr = MSR_REQ & (state==IDLE).
REQ-019 SHALL give the ALU priority unless wait_cnt == MSR_WAIT_MAX, in which case the MSR wins.
REQ-020 SHALL, on an ALU grant, load FLAGS <= ALU_FLAGS.
REQ-021 SHALL, on an MSR grant, load FLAGS <= (FLAGS & ~MSR_MASK) | (MSR_FLAGS & MSR_MASK).
REQ-022 SHALL drive STALL combinationally high only when alu_wr is high and the MSR wins; the ALU write is then not performed.
REQ-023 SHALL implement a two-state FSM: IDLE -> ACK on MSR grant; ACK -> IDLE unconditionally.
REQ-024 SHALL assert MSR_ACK for exactly the cycle spent in ACK.
REQ-025 SHALL accept ALU writes while in ACK; there is no MSR arbitration in ACK.
REQ-026 SHALL increment wait_cnt, saturating at MSR_WAIT_MAX, when msr_wr is high and the ALU wins.
REQ-027 SHALL clear wait_cnt on an MSR grant or when MSR_REQ is low.
REQ-028 SHALL register COND_PASS_VALID <= COND_VALID and COND_PASS <= eval(COND, F) each cycle, where F is the pre-write FLAGS.
REQ-029 SHALL evaluate all standard ARM conditions (EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE); AL -> 1; NV -> 0.
REQ-030 SHALL pulse FLAG_WE after an MSR write whose mask is 0000, even though FLAGS is unchanged.

Reset
REQ-031 SHALL, on RST_N low, immediately force FLAGS=0000, FLAG_WE=0, MSR_ACK=0, COND_PASS=0, COND_PASS_VALID=0, wait_cnt=0 and state=IDLE.
REQ-032 SHALL abandon an MSR write in progress when reset is asserted mid-handshake; no ACK is issued after reset release.
REQ-033 SHALL drive STALL low whenever RST_N is low.

Configuration
REQ-034 SHALL support macro FLAG_BYPASS_EN: when defined, F in REQ-028 is the post-write FLAGS value of the same cycle (same-cycle forwarding); when undefined, F is the pre-write FLAGS.

Structure
REQ-035 SHALL place the condition encodings (EQ..NV), the flag bit indices (N=3, Z=2, C=1, V=0) and the FSM state encoding in shared package flag_pkg.
REQ-036 SHALL implement condition evaluation as combinational sub-module cond_eval (inputs COND, F; output pass).

Verification
REQ-037 SHALL test: reset, then ALU_VALID=1, ALU_S=1, ALU_FLAGS=0100 -> FLAGS=0100 next cycle and FLAG_WE pulses one cycle later; with ALU_S=0, FLAGS holds.
REQ-038 SHALL test: FLAGS=1111, MSR_REQ with MSR_FLAGS=0000, MSR_MASK=1010 -> FLAGS=0101; MSR_ACK high for exactly one cycle.
REQ-039 SHALL test: MSR_REQ held high with alu_wr continuous and MSR_MAX=4 -> 4 ALU wins, then MSR wins with STALL=1 in that cycle, then the ALU write succeeds in the ACK cycle.
REQ-040 SHALL test: FLAGS=0100, COND=0000 (EQ) -> COND_PASS=1; COND=1100 (GT), FLAGS=1001 -> 1; COND=1111 -> 0.
REQ-041 SHALL test: COND_VALID coinciding with an ALU write of 0000 over FLAGS=0100, COND=EQ -> COND_PASS=1 without FLAG_BYPASS_EN, 0 with it.
REQ-042 SHALL test: RST_N dropped during the ACK state -> all outputs return to reset values asynchronously, and no MSR_ACK after release.
